fv_fifo_wr_arbiter: RTL and testbench

Shares the write port of one FV_Sync_FIFO between NUM_REQ feature-vector producers (PE output stages).
- Round-robin arbitration with packet lock: once granted, a requester keeps the port until its last beat or until BURST_MAX beats have been accepted.
- One registered output stage drives winc/wdata and holds the beat while the FIFO reports wfull.
- Sits between the PE array and the FIFO write side; the FIFO read side is untouched.

---
 rtl/fv_fifo_wr_arbiter_pkg.sv | 27 ++
 rtl/fv_fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fv_fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fv_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fv_fifo_wr_arbiter_pkg
// Shared types and defaults for the feature-vector FIFO write arbiter.
//   fv_info2fv_fifo_t : one feature-vector beat as written into FV_Sync_FIFO
//   NUM_REQ_DEF       : default number of producers sharing the write port
//   BURST_MAX_DEF     : default beats per grant before forced rotation
//   arb_state_e       : arbiter FSM states
//   next_idx()        : modulo-n increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package fv_fifo_wr_arbiter_pkg;

    localparam int FV_DATA_W     = 32;
    localparam int NUM_REQ_DEF   = 4;
    localparam int BURST_MAX_DEF = 8;

    typedef logic [FV_DATA_W-1:0] fv_info2fv_fifo_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fv_fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fv_fifo_wr_arbiter_rr_pick
// Combinational round-robin first-one finder. Searches req_valid starting at
// rr_ptr and wrapping modulo NUM_REQ.
//   req_valid : per-requester valid
//   rr_ptr    : index with highest priority this cycle
//   winner    : first valid index found from rr_ptr
//   found     : at least one requester is valid
// ---------------------------------------------------------------------------
module fv_fifo_wr_arbiter_rr_pick
    import fv_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       found
);

    localparam int PTR_W = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fv_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fv_fifo_wr_arbiter
// Shares the write port of one FV_Sync_FIFO between NUM_REQ producers.
// Round-robin arbitration with packet lock: a granted requester keeps the
// port until its last beat or until BURST_MAX beats have been accepted.
// One registered output stage drives winc/wdata and holds while wfull.
//   clk, rst_n   : clock, async active-low reset
//   req_valid    : per-requester beat valid
//   req_last     : last beat of the requester's packet
//   req_data     : per-requester beat payload
//   req_ready    : beat accepted when valid & ready
//   fifo_winc    : FIFO write enable (output stage valid)
//   fifo_wdata   : FIFO write data (output stage data)
//   fifo_wfull   : FIFO full
//   grant_id     : current / most recent owner
//   busy         : packet locked or output stage occupied
// ---------------------------------------------------------------------------
module fv_fifo_wr_arbiter
    import fv_fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  fv_info2fv_fifo_t           req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_winc,
    output fv_info2fv_fifo_t           fifo_wdata,
    input  logic                       fifo_wfull,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    fv_info2fv_fifo_t out_data_q, out_data_d;
    logic [PTR_W-1:0] grant_id_q, grant_id_d;

    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] sel;
    logic             found;
    logic             drain;
    logic             can_load;
    logic             accept;
    logic             release_now;

    fv_fifo_wr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .found     (found)
    );

    always_comb begin
        drain    = out_valid_q & ~fifo_wfull;
        can_load = ~out_valid_q | drain;
        // In IDLE the round-robin winner is offered the port; in LOCK only the owner.
        sel      = (state_q == ST_IDLE) ? winner : grant_id_q;

        req_ready = '0;
        if (rst_n && can_load && ((state_q == ST_LOCK) || found)) begin
            req_ready[sel] = 1'b1;
        end
        accept = req_valid[sel] & req_ready[sel];

        // beat_cnt is 0 in IDLE, so this also covers BURST_MAX==1 on the first beat.
        release_now = req_last[sel] | (beat_cnt_q == CNT_W'(BURST_MAX - 1));

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_id_d  = grant_id_q;

        // A load overwrites a draining beat in the same cycle for full throughput.
        if (accept) begin
            out_data_d  = req_data[sel];
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            grant_id_d = sel;
            if (release_now) begin
                state_d    = ST_IDLE;
                rr_ptr_d   = PTR_W'(next_idx(int'(sel), NUM_REQ));
                beat_cnt_d = '0;
            end else begin
                state_d    = ST_LOCK;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign fifo_winc  = out_valid_q;
    assign fifo_wdata = out_data_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q == ST_LOCK) | out_valid_q;

endmodule

// File: tb/tb_fv_fifo_wr_arbiter.sv
module tb_fv_fifo_wr_arbiter;
    import fv_fifo_wr_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int BM = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    fv_info2fv_fifo_t req_data [NR];
    logic [NR-1:0]    req_ready;
    logic             fifo_winc;
    fv_info2fv_fifo_t fifo_wdata;
    logic             fifo_wfull;
    logic [1:0]       grant_id;
    logic             busy;

    always #5 clk = ~clk;

    fv_fifo_wr_arbiter #(.NUM_REQ(NR), .BURST_MAX(BM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Per-requester source queues (stimulus) and the expected FIFO order.
    logic [31:0] src_data [NR][64];
    logic        src_last [NR][64];
    int          wr_ptr [NR] = '{default: 0};
    int          rd_ptr [NR] = '{default: 0};
    logic [NR-1:0] en;
    logic [NR-1:0] acc = '0;
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_wr  = 0;

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = en[r] && (rd_ptr[r] != wr_ptr[r]);
            req_data[r]  = src_data[r][rd_ptr[r] % 64];
            req_last[r]  = src_last[r][rd_ptr[r] % 64];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Accept is decided at the posedge; observe it mid-cycle, retire after the edge.
    always @(negedge clk) acc <= rst_n ? (req_valid & req_ready) : '0;

    always @(posedge clk) begin
        #1;
        for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
                rd_ptr[r] <= rd_ptr[r] + 1;
                n_acc     <= n_acc + 1;
            end
        end
    end

    // Scoreboard: every FIFO write must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n && fifo_winc && !fifo_wfull) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_wdata, 32'hdead_beef);
            end else begin
                chk("fifo_wdata_order", fifo_wdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic src_push(input int r, input logic [31:0] d, input logic l);
        src_data[r][wr_ptr[r] % 64] = d;
        src_last[r][wr_ptr[r] % 64] = l;
        wr_ptr[r] = wr_ptr[r] + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            done = (exp_q.size() == 0);
            for (int r = 0; r < NR; r++) begin
                if (rd_ptr[r] != wr_ptr[r]) done = 1'b0;
            end
            if (!done) tick(1);
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int gexp [5] = '{0, 1, 2, 3, 0};
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gexp [5];
        gexp = '{0, 1, 2, 3, 0};
        rst_n      = 1'b0;
        fifo_wfull = 1'b0;
        en         = '1;

        // Reset values
        #1;
        chk("rst_winc",  {31'd0, fifo_winc}, 32'd0);
        chk("rst_wdata", fifo_wdata, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        tick(2);
        rst_n = 1'b1;

        // 1: single requester, 3-beat packet, 1-cycle latency
        src_push(0, 32'h11, 1'b0);
        src_push(0, 32'h22, 1'b0);
        src_push(0, 32'h33, 1'b1);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        tick(1);
        chk("t1_winc_b1",  {31'd0, fifo_winc}, 32'd1);
        chk("t1_wdata_b1", fifo_wdata, 32'h11);
        tick(1);
        chk("t1_wdata_b2", fifo_wdata, 32'h22);
        tick(1);
        chk("t1_wdata_b3", fifo_wdata, 32'h33);
        tick(1);
        chk("t1_winc_end", {31'd0, fifo_winc}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_rr_ptr",   {30'd0, dut.rr_ptr_q}, 32'd1);

        // 2: all four valid with 1-beat packets, grant order 0,1,2,3,0
        do_reset();
        src_push(0, 32'hA0, 1'b1);
        src_push(0, 32'hA4, 1'b1);
        src_push(1, 32'hA1, 1'b1);
        src_push(2, 32'hA2, 1'b1);
        src_push(3, 32'hA3, 1'b1);
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'hA3);
        exp_q.push_back(32'hA4);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("t2_winc_every_cycle", {31'd0, fifo_winc}, 32'd1);
            chk("t2_grant_order", {30'd0, grant_id}, 32'(gexp[k]));
        end
        wait_drain("t2_drain_timeout");

        // 3: packet lock across a valid gap from the owner
        for (int b = 1; b <= 5; b++) src_push(1, 32'hB0 + 32'(b), (b == 5));
        src_push(2, 32'hC1, 1'b1);
        for (int b = 1; b <= 5; b++) exp_q.push_back(32'hB0 + 32'(b));
        exp_q.push_back(32'hC1);
        tick(2);
        en[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t3_gap_ready_req2", {31'd0, req_ready[2]}, 32'd0);
            chk("t3_gap_grant", {30'd0, grant_id}, 32'd1);
            tick(1);
        end
        en[1] = 1'b1;
        wait_drain("t3_drain_timeout");

        // 4: burst cap forces rotation after BURST_MAX beats
        do_reset();
        for (int b = 0; b < 12; b++) src_push(0, 32'hD00 + 32'(b), 1'b0);
        src_push(3, 32'hE0, 1'b1);
        for (int b = 0; b < 8; b++) exp_q.push_back(32'hD00 + 32'(b));
        exp_q.push_back(32'hE0);
        for (int b = 8; b < 12; b++) exp_q.push_back(32'hD00 + 32'(b));
        wait_drain("t4_drain_timeout");
        tick(2);

        // 5: backpressure holds the output stage
        do_reset();
        for (int b = 0; b < 4; b++) src_push(1, 32'hF0 + 32'(b), (b == 3));
        for (int b = 0; b < 4; b++) exp_q.push_back(32'hF0 + 32'(b));
        tick(1);
        fifo_wfull = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("t5_full_wdata_stable", fifo_wdata, 32'hF0);
            chk("t5_full_winc", {31'd0, fifo_winc}, 32'd1);
            chk("t5_full_ready", {28'd0, req_ready}, 32'd0);
        end
        fifo_wfull = 1'b0;
        wait_drain("t5_drain_timeout");
        tick(2);
        chk("t5_written_eq_accepted", 32'(n_wr), 32'(n_acc));

        // 6: asynchronous reset in the middle of a packet
        do_reset();
        for (int b = 0; b < 4; b++) src_push(2, 32'h60 + 32'(b), (b == 3));
        exp_q.push_back(32'h60);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_winc",  {31'd0, fifo_winc}, 32'd0);
        chk("t6_rst_wdata", fifo_wdata, 32'd0);
        chk("t6_rst_ready", {28'd0, req_ready}, 32'd0);
        chk("t6_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t6_rst_grant", {30'd0, grant_id}, 32'd0);
        wr_ptr[2] = rd_ptr[2];
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t6_rr_ptr_after", {30'd0, dut.rr_ptr_q}, 32'd0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        chk("t6_partial_written", 32'(exp_q.size()), 32'd0);
        src_push(3, 32'h77, 1'b1);
        exp_q.push_back(32'h77);
        wait_drain("t6_drain_timeout");
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
